// File: rtl/fir_s2p_deserializer_if.sv
// Serial-in / 4-lane parallel-out bus for fir_s2p_deserializer.
// The master drives the serial stream, and the slave returns the assembled blocks.
interface fir_s2p_deserializer_if #(
   parameter int NB_DATA = 19
);
   logic                      i_enable;
   logic signed [NB_DATA-1:0] i_data;
   logic                      i_valid;
   logic                      i_sof;
   logic signed [NB_DATA-1:0] o_data_0;
   logic signed [NB_DATA-1:0] o_data_1;
   logic signed [NB_DATA-1:0] o_data_2;
   logic signed [NB_DATA-1:0] o_data_3;
   logic                      o_valid;
   logic [1:0]                o_phase;
   logic                      o_align_err;
   logic [7:0]                o_block_cnt;

   modport master (
      output i_enable, i_data, i_valid, i_sof,
      input  o_data_0, o_data_1, o_data_2, o_data_3,
      input  o_valid, o_phase, o_align_err, o_block_cnt
   );

   modport slave (
      input  i_enable, i_data, i_valid, i_sof,
      output o_data_0, o_data_1, o_data_2, o_data_3,
      output o_valid, o_phase, o_align_err, o_block_cnt
   );
endinterface

// File: rtl/fir_s2p_deserializer.sv
// Gathers a serial sample stream into 4-lane blocks, aligned on i_sof.
// The block is published atomically when lane 3 arrives, and a misplaced sof restarts the block.
module fir_s2p_deserializer #(
   parameter int NB_DATA = 19,
   parameter int N_PARAL = 4
) (
   input logic                    clock_4,
   input logic                    i_reset,
   fir_s2p_deserializer_if.slave  bus
);
   localparam logic [1:0] LAST_LANE = 2'(N_PARAL - 1);

   typedef enum logic {UNSYNC, COLLECT} state_t;

   state_t             state_q,  state_d;
   logic [1:0]         phase_q,  phase_d;
   logic [NB_DATA-1:0] shadow_q [3];
   logic [NB_DATA-1:0] shadow_d [3];
   logic [NB_DATA-1:0] lane_q   [4];
   logic [NB_DATA-1:0] lane_d   [4];
   logic               valid_q,  valid_d;
   logic               err_q,    err_d;
   logic [7:0]         cnt_q,    cnt_d;

   logic accept;
   assign accept = bus.i_enable & bus.i_valid;

   always_comb begin
      // NOTE: every output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
      state_d  = state_q;
      phase_d  = phase_q;
      shadow_d = shadow_q;
      lane_d   = lane_q;
      valid_d  = 1'b0;
      err_d    = err_q;
      cnt_d    = cnt_q;

      if (accept) begin
         if (bus.i_sof && (state_q == UNSYNC || phase_q != 2'd0)) begin
            // This is the first sof, or a resync that drops a partial block.
            shadow_d[0] = bus.i_data;
            phase_d     = 2'd1;
            state_d     = COLLECT;
            if (state_q == COLLECT) err_d = 1'b1;
         end else if (state_q == COLLECT) begin
            if (phase_q == LAST_LANE) begin
               lane_d[0] = shadow_q[0];
               lane_d[1] = shadow_q[1];
               lane_d[2] = shadow_q[2];
               lane_d[3] = bus.i_data;
               valid_d   = 1'b1;
               cnt_d     = cnt_q + 8'd1;
               phase_d   = 2'd0;
            end else begin
               case (phase_q)
                  2'd0:    shadow_d[0] = bus.i_data;
                  2'd1:    shadow_d[1] = bus.i_data;
                  default: shadow_d[2] = bus.i_data;
               endcase
               phase_d = phase_q + 2'd1;
            end
         end
      end
   end

   // NOTE: non-blocking assignments for all state, so every flop samples the pre-edge values.
   always_ff @(posedge clock_4) begin
      if (!i_reset) begin
         state_q  <= UNSYNC;
         phase_q  <= 2'd0;
         // NOTE: the shadow and output lanes are cleared too, because zeros after reset are observable on o_data.
         shadow_q <= '{default: '0};
         lane_q   <= '{default: '0};
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= 8'd0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         shadow_q <= shadow_d;
         lane_q   <= lane_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.o_data_0    = lane_q[0];
   assign bus.o_data_1    = lane_q[1];
   assign bus.o_data_2    = lane_q[2];
   assign bus.o_data_3    = lane_q[3];
   assign bus.o_valid     = valid_q;
   assign bus.o_phase     = phase_q;
   assign bus.o_align_err = err_q;
   assign bus.o_block_cnt = cnt_q;
endmodule

// File: doc/fir_s2p_deserializer.md
FIR_S2P_DESERIALIZER -- requirements
Module: fir_s2p_deserializer

Interface
- REQ-001 The block SHALL have parameter NB_DATA, default 19, meaning width of one signed sample.
- REQ-002 The block SHALL have parameter N_PARAL, default 4, meaning number of parallel lanes; only the value 4 is supported.
- REQ-003 The block SHALL have input clock_4, 1 bit: the fast (4x) serial-rate clock; all logic is on its rising edge.
- REQ-004 The block SHALL have input i_reset, 1 bit: synchronous, active-low reset.
- REQ-005 The block SHALL have input i_enable, 1 bit: global enable; when low, all state freezes.
- REQ-006 The block SHALL have input i_data, NB_DATA bits, signed: the serial sample stream.
- REQ-007 The block SHALL have input i_valid, 1 bit: i_data holds a sample this cycle.
- REQ-008 The block SHALL have input i_sof, 1 bit: the sample qualified by i_valid is lane 0 of a block.
- REQ-009 The block SHALL have outputs o_data_0 to o_data_3, each NB_DATA bits, signed: parallel block lanes 0 to 3.
- REQ-010 The block SHALL have output o_valid, 1 bit: one-cycle pulse when a new block is on o_data_0..3.
- REQ-011 The block SHALL have output o_phase, 2 bits: the lane index the next accepted sample will fill.
- REQ-012 The block SHALL have output o_align_err, 1 bit: sticky flag set when a partial block is discarded.
- REQ-013 The block SHALL have output o_block_cnt, 8 bits: count of emitted blocks, wrapping 255 to 0.

Function
- REQ-014 A sample SHALL be accepted when i_enable=1 and i_valid=1; no other sample is accepted.
- REQ-015 The FSM SHALL have two states, UNSYNC and COLLECT, and SHALL enter UNSYNC on reset.
- REQ-016 In UNSYNC, accepted samples with i_sof=0 SHALL be dropped and o_phase SHALL stay 0.
- REQ-017 In UNSYNC, an accepted sample with i_sof=1 SHALL be stored as lane 0, set o_phase to 1, and move the FSM to COLLECT.
- REQ-018 In COLLECT, an accepted sample with i_sof=0 SHALL be stored in lane o_phase, then o_phase increments modulo 4.
- REQ-019 The samples for lanes 0 to 2 SHALL be held in a shadow register; o_data_0..3 SHALL NOT change while a block is partial.
- REQ-020 When the lane-3 sample is accepted, o_data_0..3 SHALL load shadow lanes 0..2 plus that sample on the same edge, and o_valid SHALL be 1 for exactly the following cycle.
- REQ-021 Latency SHALL be 1 clock_4 cycle from the accepted lane-3 sample to o_valid=1.
- REQ-022 o_data_0..3 SHALL hold their values until the next block completes.
- REQ-023 o_block_cnt SHALL increment by 1 on the same edge that o_valid is asserted.
- REQ-024 In COLLECT, an accepted sample with i_sof=1 and o_phase=0 SHALL be treated as the normal lane-0 sample.
- REQ-025 In COLLECT, an accepted sample with i_sof=1 and o_phase not 0 SHALL discard the partial block (no o_valid), store the sample as lane 0, set o_phase to 1, and set o_align_err.
- REQ-026 o_align_err SHALL be cleared only by reset.
- REQ-027 When i_enable=0, the FSM, shadow lanes, o_phase and o_block_cnt SHALL hold, and o_valid SHALL be 0.
- REQ-028 Data SHALL pass through unmodified at full NB_DATA width, with no rounding and no sign change.

Reset
- REQ-029 With i_reset=0 at a clock_4 edge, the FSM SHALL go to UNSYNC and o_data_0..3, shadow lanes, o_valid, o_phase, o_align_err and o_block_cnt SHALL all become 0.
- REQ-030 A reset in the middle of a block SHALL discard the partial block without emitting o_valid.
- REQ-031 Reset SHALL take priority over i_enable.

Verification
- REQ-032 Reset, then valid samples 5,6,7 with i_sof=0 -> all dropped; o_phase=0; o_valid never asserted.
- REQ-033 Samples 1(sof),2,3,4 on consecutive cycles -> one cycle later o_valid=1 with o_data_0..3 = 1,2,3,4 and o_block_cnt=1.
- REQ-034 Samples 1(sof),2,9(sof),10,11,12 -> o_align_err=1; single block emitted = 9,10,11,12.
- REQ-035 Samples 1(sof),2, then i_valid=0 for 3 cycles, then 3,4 -> block 1,2,3,4 emitted; o_data held steady through the gap.
- REQ-036 Samples -1(sof),-2 with i_enable dropped for 2 cycles, then -3,-4 -> block -1,-2,-3,-4 emitted; o_valid=0 while disabled.
- REQ-037 Stream 256 back-to-back blocks -> o_block_cnt wraps to 0; i_reset=0 during a later lane-2 sample -> all outputs 0 and no o_valid.
